// File: rtl/keccak_pad_stream_pkg.sv
// keccak_pad_stream_pkg: mode encodings, rate table and pad byte constants
// shared by the Keccak stream padder and its byte-lane padder.
package keccak_pad_stream_pkg;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'b00,
        MODE_SHA3_512 = 2'b01,
        MODE_SHAKE128 = 2'b10,
        MODE_SHAKE256 = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAD,
        S_DONE
    } state_t;

    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] DOM_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_FINAL = 8'h80;

    function automatic int rate_bytes(input logic [1:0] mode);
        return (mode == MODE_SHA3_512) ? 72 : (mode == MODE_SHAKE128) ? 168 : 136;
    endfunction

    function automatic logic [7:0] domain_byte(input logic [1:0] mode);
        return mode[1] ? DOM_SHAKE : DOM_SHA3;
    endfunction

endpackage

// File: rtl/keccak_pad_stream_lane.sv
// keccak_pad_stream_lane: combinational per-word padder; keeps the leading run of valid
// bytes, drops the domain byte into the first invalid lane and ORs the final pad bit on top.
module keccak_pad_stream_lane
    import keccak_pad_stream_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]   data,
    input  logic [W/8-1:0] keep,
    input  logic           first_pad,
    input  logic           block_end,
    input  logic [1:0]     mode,
    output logic [W-1:0]   word
);

    localparam int B = W / 8;

    logic run;
    logic hit;

    // A hole in keep ends the message: every byte above the first zero is padding.
    always_comb begin
        run  = 1'b1;
        hit  = 1'b0;
        word = '0;
        for (int i = 0; i < B; i++) begin
            hit = run & ~keep[i];
            run = run & keep[i];
            word[8*i +: 8] = run ? data[8*i +: 8] : (hit & first_pad) ? domain_byte(mode) : 8'h00;
        end
        word[W-1 -: 8] = word[W-1 -: 8] | (block_end ? PAD_FINAL : 8'h00);
    end

endmodule

// File: rtl/keccak_pad_stream.sv
// keccak_pad_stream: byte-granular message stream to W-bit absorb words with SHA3/SHAKE
// pad10*1, tracking rate-block boundaries and emitting trailing pad words on its own.
module keccak_pad_stream
    import keccak_pad_stream_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     mode,
    input  logic [W-1:0]   in_data,
    input  logic [W/8-1:0] in_keep,
    input  logic           in_last,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_block_last,
    output logic           out_msg_last,
    output logic           busy
);

    localparam int B = W / 8;

    state_t         state, state_n;
    logic [1:0]     mode_q, cur_mode;
    logic [CNT_W-1:0] wcnt, rate_last;
    logic           dom_pend, dom_pend_n;
    logic           load, accept, fresh, at_end, partial;
    logic           do_load, msg_last_n, lane_first, lane_end;
    logic [W-1:0]   lane_data, padded;
    logic [B-1:0]   lane_keep;

    assign load      = ~out_valid | out_ready;
    assign in_ready  = (state != S_PAD) & load;
    assign accept    = in_valid & in_ready;
    // DONE behaves like IDLE for a new first word, since that word can only enter as msg_last leaves.
    assign fresh     = (state == S_IDLE) | (state == S_DONE);
    assign cur_mode  = fresh ? mode : mode_q;
    assign rate_last = CNT_W'(rate_bytes(cur_mode) / B - 1);
    assign at_end    = wcnt == rate_last;
    assign partial   = ~&in_keep;
    assign busy      = state != S_IDLE;

    keccak_pad_stream_lane #(.W(W)) u_lane (
        .data      (lane_data),
        .keep      (lane_keep),
        .first_pad (lane_first),
        .block_end (lane_end),
        .mode      (cur_mode),
        .word      (padded)
    );

    always_comb begin
        state_n    = state;
        dom_pend_n = dom_pend;
        do_load    = 1'b0;
        msg_last_n = 1'b0;
        lane_data  = '0;
        lane_keep  = '0;
        lane_first = dom_pend;
        lane_end   = at_end;
        if (state == S_PAD) begin
            if (load) begin
                do_load    = 1'b1;
                msg_last_n = at_end;
                dom_pend_n = 1'b0;
                state_n    = at_end ? S_DONE : S_PAD;
            end
        end else if (accept) begin
            do_load    = 1'b1;
            lane_data  = in_data;
            lane_keep  = in_last ? in_keep : '1;
            lane_first = 1'b1;
            // A full final word leaves the domain byte (and possibly a whole block) to PAD.
            lane_end   = in_last & partial & at_end;
            msg_last_n = lane_end;
            dom_pend_n = in_last & ~partial;
            state_n    = !in_last ? S_DATA : lane_end ? S_DONE : S_PAD;
        end else if (state == S_DONE && out_ready) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            dom_pend       <= 1'b0;
            mode_q         <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else begin
            state    <= state_n;
            dom_pend <= dom_pend_n;
            if (accept && fresh) mode_q <= mode;
            if (do_load) begin
                out_valid      <= 1'b1;
                out_data       <= padded;
                out_block_last <= at_end;
                out_msg_last   <= msg_last_n;
                wcnt           <= at_end ? '0 : wcnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
